// File: rtl/quad_pkg.sv
// Shared constants and types for the quad flight-controller output stages.
package quad_pkg;
    localparam int CLK_HZ       = 50_000_000;
    localparam int FRAME_CYCLES = 1_000_000;
    localparam int MIN_PULSE    = 50_000;
    localparam int STEP         = 50;
    localparam int MAX_RATIO    = 1000;
    localparam int RATIO_W      = 13;

    typedef enum logic {
        ARMING = 1'b0,
        RUN    = 1'b1
    } esc_state_t;
endpackage

// File: rtl/pwm_frame_timer.sv
// Free-running frame counter shared by fixed-period output stages.
// Flags the last cycle of a frame and pulses frame_start one cycle after cnt == 0.
module pwm_frame_timer #(
    parameter int FRAME_CYCLES = 1_000_000,
    localparam int CW = $clog2(FRAME_CYCLES)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] cnt,
    output logic          last_cycle,
    output logic          frame_start
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          frame_start_q, frame_start_d;

    always_comb begin
        last_cycle    = (cnt_q == CW'(FRAME_CYCLES - 1));
        cnt_d         = last_cycle ? '0 : cnt_q + 1'b1;
        frame_start_d = (cnt_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign cnt         = cnt_q;
    assign frame_start = frame_start_q;
endmodule

// File: rtl/esc_pwm_gen.sv
// ESC servo-style PWM generator: one command latched per frame, clamped, then
// gated by an arming sequence. Define ESC_ARM_EN to include the arming state.
module esc_pwm_gen
    import quad_pkg::*;
#(
    parameter int FRAME_CYCLES = quad_pkg::FRAME_CYCLES,
    parameter int MIN_PULSE    = quad_pkg::MIN_PULSE,
    parameter int STEP         = quad_pkg::STEP,
    parameter int MAX_RATIO    = quad_pkg::MAX_RATIO,
    parameter int ARM_FRAMES   = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RATIO_W-1:0] ratio,
    input  logic               enable,
    output logic               pwm_out,
    output logic               frame_start,
    output logic               armed
);
    localparam int CW    = $clog2(FRAME_CYCLES);
    localparam int HW    = $clog2(MIN_PULSE + MAX_RATIO * STEP + 1);
    localparam int CMP_W = (CW > HW) ? CW : HW;

    logic [CW-1:0]      cnt;
    logic               last_cycle;
    logic [RATIO_W-1:0] cmd;
    esc_state_t         state_q, state_d;
    logic [HW-1:0]      high_cycles_q, high_cycles_d;
    logic               pwm_q, pwm_d;

    pwm_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .cnt         (cnt),
        .last_cycle  (last_cycle),
        .frame_start (frame_start)
    );

`ifdef ESC_ARM_EN
    localparam int AW = $clog2(ARM_FRAMES + 1);
    logic [AW-1:0] arm_cnt_q, arm_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) arm_cnt_q <= '0;
        else     arm_cnt_q <= arm_cnt_d;
    end

    assign armed = (state_q == RUN);
`else
    // Without arming the frame count has no effect.
    logic unused_arm_cfg;
    assign unused_arm_cfg = (ARM_FRAMES != 0);
    assign armed = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        high_cycles_d = high_cycles_q;
        cmd           = '0;
`ifdef ESC_ARM_EN
        arm_cnt_d     = arm_cnt_q;
`endif
        if (last_cycle) begin
`ifdef ESC_ARM_EN
            if (state_q == ARMING) begin
                if (arm_cnt_q == AW'(ARM_FRAMES - 1)) state_d = RUN;
                else                                  arm_cnt_d = arm_cnt_q + 1'b1;
            end
`endif
            // Use the next state so the frame that finishes arming already follows ratio.
            if (enable && state_d == RUN)
                cmd = (ratio > RATIO_W'(MAX_RATIO)) ? RATIO_W'(MAX_RATIO) : ratio;
            high_cycles_d = HW'(MIN_PULSE) + HW'(cmd) * HW'(STEP);
        end
        pwm_d = (CMP_W'(cnt) < CMP_W'(high_cycles_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef ESC_ARM_EN
            state_q <= ARMING;
`else
            state_q <= RUN;
`endif
            high_cycles_q <= HW'(MIN_PULSE);
            pwm_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            high_cycles_q <= high_cycles_d;
            pwm_q         <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;
endmodule

// File: tb/tb_esc_pwm_gen.sv
// Directed bench for esc_pwm_gen with shrunk frame parameters.
module tb_esc_pwm_gen;
    localparam int FC   = 1000;
    localparam int MINP = 50;
    localparam int STP  = 1;
    localparam int MAXR = 100;
    localparam int ARMF = 3;
`ifdef ESC_ARM_EN
    localparam bit ARM_EN = 1'b1;
`else
    localparam bit ARM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [12:0] ratio;
    logic        pwm_out, frame_start, armed;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    esc_pwm_gen #(
        .FRAME_CYCLES (FC),
        .MIN_PULSE    (MINP),
        .STEP         (STP),
        .MAX_RATIO    (MAXR),
        .ARM_FRAMES   (ARMF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ratio       (ratio),
        .enable      (enable),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .armed       (armed)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (frame_start !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, int'(frame_start), 1);
    endtask

    // Runs one frame from a frame_start sample to the next one; optionally
    // changes ratio/enable at the given cycle offset within the frame.
    task automatic frame(input string tag, input int chg_at, input int r, input logic en,
                         input int exp_hi, input logic exp_arm);
        int hi = 0;
        int per = 0;
        chk({tag, "_armed"}, int'(armed), int'(exp_arm));
        do begin
            if (per == chg_at) begin
                ratio  = 13'(r);
                enable = en;
            end
            hi += int'(pwm_out);
            per++;
            @(negedge clk);
        end while (frame_start !== 1'b1 && per < 2 * FC);
        chk({tag, "_high"}, hi, exp_hi);
        chk({tag, "_period"}, per, FC);
    endtask

    initial begin
        rst    = 1'b1;
        ratio  = 13'd80;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_fs", int'(frame_start), 0);
        chk("rst_armed", int'(armed), ARM_EN ? 0 : 1);
        rst = 1'b0;
        @(negedge clk);
        wait_start("boot");

        if (ARM_EN) begin
            frame("arm1", -1, 80, 1'b1, MINP, 1'b0);
            frame("arm2", -1, 80, 1'b1, MINP, 1'b0);
            frame("arm3", -1, 80, 1'b1, MINP, 1'b0);
        end else begin
            frame("first", -1, 80, 1'b1, MINP, 1'b1);
        end
        frame("cmd80",     5, 4000, 1'b1, 130, 1'b1);
        frame("clamp4000", 5, 100,  1'b1, 150, 1'b1);
        frame("clamp100",  5, 0,    1'b1, 150, 1'b1);
        frame("ratio0",    5, 20,   1'b1, 50,  1'b1);
        frame("mid20",     9, 90,   1'b1, 70,  1'b1);
        frame("mid90",   499, 90,   1'b0, 140, 1'b1);
        frame("en_off",    5, 90,   1'b1, 50,  1'b1);
        frame("en_back",  -1, 90,   1'b1, 140, 1'b1);

        // Async reset part-way through a pulse.
        repeat (29) @(negedge clk);
        chk("pre_rst_pwm", int'(pwm_out), 1);
        rst = 1'b1;
        #1;
        chk("async_pwm", int'(pwm_out), 0);
        chk("async_armed", int'(armed), ARM_EN ? 0 : 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wait_start("rearm");
        if (ARM_EN) begin
            frame("rearm1", -1, 90, 1'b1, MINP, 1'b0);
            frame("rearm2", -1, 90, 1'b1, MINP, 1'b0);
            frame("rearm3", -1, 90, 1'b1, MINP, 1'b0);
        end else begin
            frame("refirst", -1, 90, 1'b1, MINP, 1'b1);
        end
        frame("rearmed", -1, 90, 1'b1, 140, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/esc_pwm_gen.md
# esc_pwm_gen

Downstream stage of the PWM-capture block. Consumes its 13-bit throttle ratio (0..1000) and drives one ESC servo-style PWM output: 50 Hz frame, high time 1.000–2.000 ms at a 50 MHz clock. Each frame latches one command at the frame boundary, clamps it, and gates it through an arming sequence so the ESC sees minimum throttle after power-up.

## Interface
- FRAME_CYCLES, default 1_000_000: clocks per frame (20 ms @ 50 MHz).
- MIN_PULSE, default 50_000: high cycles at ratio 0 (1 ms).
- STEP, default 50: high cycles added per ratio LSB.
- MAX_RATIO, default 1000: ratio clamp ceiling.
- ARM_FRAMES, default 100: minimum-throttle frames before commands pass (2 s).
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; asynchronous, active-high.
- ratio  in  13  throttle command from the capture stage, 0..MAX_RATIO nominal.
- enable  in  1  1 = follow ratio; 0 = force minimum pulse.
- pwm_out  out  1  ESC signal, registered.
- frame_start  out  1  one-cycle pulse on the first cycle of each frame.
- armed  out  1  high once arming is complete.

## Operation
- Frame counter `cnt` (width $clog2(FRAME_CYCLES)) counts 0..FRAME_CYCLES-1, then wraps to 0.
- States: ARMING, RUN.
  - ARMING: latched command forced to 0. Each completed frame increments `arm_cnt`. When `arm_cnt` reaches ARM_FRAMES-1 and a frame wraps, go to RUN and set armed = 1.
  - RUN: the command is latched from ratio at the wrap. Stays in RUN until rst.
- Latch point: the cycle with cnt == FRAME_CYCLES-1. The new `high_cycles` takes effect for the frame beginning on the next cycle. Changes to ratio mid-frame never alter the current pulse.
- Command formation, in order:
  - enable == 0 or state ARMING → 0.
  - Otherwise, ratio > MAX_RATIO → MAX_RATIO.
  - Otherwise → ratio.
- high_cycles = MIN_PULSE + cmd*STEP.
  - Computed at width $clog2(MIN_PULSE + MAX_RATIO*STEP + 1) (17 bits at defaults). No truncation.
- pwm_out <= (cnt < high_cycles). frame_start <= (cnt == 0).

## Timing
- Reset values:
  - cnt = 0, arm_cnt = 0, state = ARMING.
  - high_cycles = MIN_PULSE.
  - pwm_out = 0, frame_start = 0, armed = 0.
- After rst deasserts, the first rising edge sees cnt = 0. pwm_out and frame_start rise one cycle later, so outputs carry 1-cycle registered latency relative to cnt.
- Pulse width is exactly high_cycles clocks. Frame period is exactly FRAME_CYCLES clocks.
- Ratio latency: a value stable on the latch cycle appears at the next frame's rising edge, 2 cycles after the latch cycle.
- Boundaries:
  - ratio = 0 gives 50_000 cycles. ratio = 1000 gives 100_000 cycles. ratio 1001..8191 clamps to 100_000.
  - enable falling mid-frame: current pulse completes unchanged; the next frame is at minimum.
  - Wrap with a simultaneous ARMING→RUN transition: the frame starting at that wrap already uses the latched ratio.
  - rst mid-pulse: pwm_out drops to 0 asynchronously, and arming restarts from 0.

## Configuration
- ESC_ARM_EN:
  - Defined: the ARMING state and arm_cnt are present, as described above.
  - Undefined: reset state is RUN, armed is tied to 1, arm_cnt is omitted, and the first frame after reset uses MIN_PULSE. Commands then pass from the first latch.

## Structure
- Shared package `quad_pkg`:
  - CLK_HZ = 50_000_000.
  - PWM frame/pulse constants: FRAME_CYCLES, MIN_PULSE, STEP, MAX_RATIO.
  - RATIO_W = 13.
  - State enum `esc_state_t {ARMING, RUN}`.
- Sub-module `pwm_frame_timer`:
  - Owns cnt and the wrap/frame_start logic.
  - Exports `last_cycle` and `cnt`.
  - Reused by other fixed-period output stages.

## Test plan
Benches shrink parameters: FRAME_CYCLES = 1000, MIN_PULSE = 50, STEP = 1, MAX_RATIO = 100, ARM_FRAMES = 3.
- Reset/arming: rst, ratio = 80, enable = 1 → frames 1–3 high 50 cycles with armed = 0; frame 4 high 130 cycles with armed = 1.
- Clamp: armed, ratio = 4000 → high 150 cycles. ratio = 100 → 150. ratio = 0 → 50.
- Mid-frame change: ratio 20→90 at cnt = 10 → current frame 70 cycles, next frame 140 cycles. Period stays 1000 cycles.
- Enable drop: enable = 0 at cnt = 500 → current frame unchanged, next frame 50 cycles. Re-enable restores the command the following frame.
- Async reset mid-pulse: rst at cnt = 30 → pwm_out = 0 in the same cycle, armed = 0, arming restarts at 3 frames.
- ESC_ARM_EN undefined: ratio = 60 after reset → first frame 50 cycles, second frame 110 cycles, armed = 1 throughout.
